// File: rtl/kws_psram_arbiter_if.sv
// Requester/controller bundle for the PSRAM arbiter.
// The arbiter takes the slave view; requesters and the controller take the master view.
interface kws_psram_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 8
);
  logic [2:0]          req;
  logic [2:0]          req_we;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*LEN_W-1:0]  req_len;
  logic [3*32-1:0]     req_wdata;
  logic [2:0]          gnt;
  logic [2:0]          wready;
  logic [2:0]          rvalid;
  logic [31:0]         rdata;
  logic [2:0]          done;
  logic [2:0]          err;
  logic                mc_start;
  logic                mc_abort;
  logic                mc_we;
  logic [ADDR_W-1:0]   mc_addr;
  logic [LEN_W-1:0]    mc_len;
  logic [31:0]         mc_wdata;
  logic                mc_wready;
  logic                mc_rvalid;
  logic                mc_done;
  logic [31:0]         mc_rdata;

  modport slave (
    input  req, req_we, req_addr, req_len, req_wdata,
    input  mc_wready, mc_rvalid, mc_done, mc_rdata,
    output gnt, wready, rvalid, rdata, done, err,
    output mc_start, mc_abort, mc_we, mc_addr, mc_len, mc_wdata
  );

  modport master (
    output req, req_we, req_addr, req_len, req_wdata,
    output mc_wready, mc_rvalid, mc_done, mc_rdata,
    input  gnt, wready, rvalid, rdata, done, err,
    input  mc_start, mc_abort, mc_we, mc_addr, mc_len, mc_wdata
  );
endinterface

// File: rtl/kws_psram_arbiter.sv
// Round-robin arbiter sharing one QSPI PSRAM controller among three requesters,
// with a watchdog that force-releases the controller on a hung transaction.
module kws_psram_arbiter #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic               clk,
  input logic               rst,
  kws_psram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RELEASE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t              state, state_nxt;
  logic [1:0]          owner, owner_nxt;
  logic [1:0]          last, last_nxt;
  logic [15:0]         cnt, cnt_nxt;
  logic [2:0]          gnt, gnt_nxt;
  logic [2:0]          done, done_nxt;
  logic [2:0]          err, err_nxt;
  logic                start, start_nxt;
  logic                we, we_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [LEN_W-1:0]    len, len_nxt;
  logic [1:0]          winner, idx;
  logic                found;
  logic                timeout_hit;
  logic                busy;
  logic [31:0]         wdata_sel;

  assign busy = (state == BUSY);
  // mc_done in the final watchdog cycle must suppress the abort, so this decode sees mc_done directly
  assign timeout_hit = busy && (cnt == CNT_LAST) && !bus.mc_done;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      idx = 2'((32'(last) + 32'd1 + i) % 32'd3);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    err_nxt   = '0;
    start_nxt = 1'b0;
    we_nxt    = we;
    addr_nxt  = addr;
    len_nxt   = len;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = winner;
          we_nxt    = bus.req_we[winner];
          addr_nxt  = bus.req_addr[32'(winner)*ADDR_W +: ADDR_W];
          len_nxt   = bus.req_len[32'(winner)*LEN_W +: LEN_W];
          gnt_nxt   = 3'b001 << winner;
          start_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.mc_done || timeout_hit) begin
          done_nxt  = gnt;
          err_nxt   = timeout_hit ? gnt : 3'b000;
          gnt_nxt   = '0;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = 16'(cnt + 16'd1);
        end
      end
      RELEASE: begin
        last_nxt  = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= 2'd2;
      cnt   <= '0;
      gnt   <= '0;
      done  <= '0;
      err   <= '0;
      start <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      start <= start_nxt;
      we    <= we_nxt;
      addr  <= addr_nxt;
      len   <= len_nxt;
    end
  end

  always_comb begin
    wdata_sel = '0;
    case (owner)
      2'd0:    wdata_sel = bus.req_wdata[31:0];
      2'd1:    wdata_sel = bus.req_wdata[63:32];
      2'd2:    wdata_sel = bus.req_wdata[95:64];
      default: wdata_sel = '0;
    endcase
  end

  assign bus.gnt      = gnt;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.mc_start = start;
  assign bus.mc_abort = timeout_hit;
  assign bus.mc_we    = we;
  assign bus.mc_addr  = addr;
  assign bus.mc_len   = len;
  assign bus.mc_wdata = (gnt != 3'b000) ? wdata_sel : '0;
  assign bus.wready   = (busy && bus.mc_wready) ? gnt : 3'b000;
  assign bus.rvalid   = (busy && bus.mc_rvalid) ? gnt : 3'b000;
  assign bus.rdata    = bus.mc_rdata;

endmodule
